// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_pkg
// Description : Shared types and default widths for the store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int PHY_W_DEF    = 6;

    // Default-width view of one buffered store.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } sb_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sb_state_e;

    function automatic int sb_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sb_fifo_ctrl
// Description : Wrap-bit read/write pointers, occupancy and full/empty status.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fifo_ctrl
    import sb_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        push_i,
    input  logic                        pop_i,
    output logic                        push_ok_o,
    output logic [$clog2(SB_DEPTH)-1:0] wr_idx_o,
    output logic [$clog2(SB_DEPTH)-1:0] rd_idx_o,
    output logic [$clog2(SB_DEPTH):0]   count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int PTR_W = sb_ptr_w(SB_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             pop_ok;

    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;

    // Full is taken from registered pointers: a push into a full buffer is
    // dropped even if the head pops on the same edge.
    assign push_ok_o = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push_ok_o);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);

    assign wr_idx_o = wr_ptr_q[PTR_W-2:0];
    assign rd_idx_o = rd_ptr_q[PTR_W-2:0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : In-order buffer of committed stores draining to data memory.
//               Optional store-to-load forwarding CAM under SB_LD_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import sb_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PHY_W    = PHY_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      rob_commit,
    input  logic                      rob_commitmemwrite,
    input  logic [ADDR_W-1:0]         rob_swaddr,
    input  logic [PHY_W-1:0]          rob_commitcurrphyaddr,
    output logic [PHY_W-1:0]          sb_prf_rdaddr,
    input  logic [DATA_W-1:0]         prf_rddata,
    output logic                      sb_full,
    output logic                      sb_empty,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_mem_req,
    output logic [ADDR_W-1:0]         sb_mem_addr,
    output logic [DATA_W-1:0]         sb_mem_wdata,
    input  logic                      mem_ack
`ifdef SB_LD_FWD_EN
    ,
    input  logic [ADDR_W-1:0]         ld_addr,
    output logic                      sb_fwd_hit,
    output logic [DATA_W-1:0]         sb_fwd_data
`endif
);

    localparam int PTR_W = sb_ptr_w(SB_DEPTH);
    localparam int IDX_W = PTR_W - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           entries_q [SB_DEPTH];
    sb_state_e        state_q;
    logic             mem_req_q;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [PTR_W-1:0] remain;

    assign push          = rob_commit & rob_commitmemwrite;
    assign pop           = (state_q == REQ) & mem_ack;
    assign sb_prf_rdaddr = rob_commitcurrphyaddr;

    sb_fifo_ctrl #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fifo_ctrl (
        .clk       (clk),
        .rst_b     (rst_b),
        .push_i    (push),
        .pop_i     (pop),
        .push_ok_o (push_ok),
        .wr_idx_o  (wr_idx),
        .rd_idx_o  (rd_idx),
        .count_o   (sb_count),
        .full_o    (sb_full),
        .empty_o   (sb_empty)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (push_ok) begin
            entries_q[wr_idx] <= '{addr: rob_swaddr, data: prf_rddata};
        end
    end

    // Occupancy after this edge's pop; only meaningful in REQ, where count>=1.
    assign remain = sb_count - PTR_W'(1) + PTR_W'(push_ok);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sb_count != '0) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack && (remain == '0)) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign sb_mem_req   = mem_req_q;
    assign sb_mem_addr  = entries_q[rd_idx].addr;
    assign sb_mem_wdata = entries_q[rd_idx].data;

    always @(posedge clk) begin
        if (rst_b) begin
            assert (!(push && sb_full))
                else $error("store_buffer: store committed while buffer full");
        end
    end

`ifdef SB_LD_FWD_EN
    logic [IDX_W-1:0] cam_idx;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sb_fwd_hit  = 1'b0;
        sb_fwd_data = '0;
        cam_idx     = rd_idx;
        for (int i = 0; i < SB_DEPTH; i++) begin
            cam_idx = rd_idx + IDX_W'(i);
            if ((PTR_W'(i) < sb_count) && (entries_q[cam_idx].addr == ld_addr)) begin
                sb_fwd_hit  = 1'b1;
                sb_fwd_data = entries_q[cam_idx].data;
            end
        end
    end
`endif

endmodule
`default_nettype wire
